// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - fetch-coordinate and VGA DAC signal bundle for vga_timing_gen
interface vga_timing_gen_if #(
  parameter int COORD_W = 10
);
  logic [23:0]        color_in;
  logic               fetch_valid;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               line_start;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic               blank_n;
  logic               sync_n;
  logic               vga_clk;
  logic [7:0]         red;
  logic [7:0]         green;
  logic [7:0]         blue;

  modport master (
    input  color_in,
    output fetch_valid, next_x, next_y, line_start, frame_start,
    output hsync, vsync, blank_n, sync_n, vga_clk, red, green, blue
  );

  modport slave (
    output color_in,
    input  fetch_valid, next_x, next_y, line_start, frame_start,
    input  hsync, vsync, blank_n, sync_n, vga_clk, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - programmable VGA timing with early pixel fetch; VGA_TIMING_TESTPAT_EN selects internal colour bars
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_PULSE   = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_PULSE   = 2,
  parameter int V_BACK    = 33,
  parameter int H_POL     = 0,
  parameter int V_POL     = 0,
  parameter int LATENCY   = 2,
  parameter int GRAY_MODE = 1,
  parameter int COORD_W   = 10
) (
  input  logic             clock,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_PULSE;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_PULSE;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

`ifdef VGA_TIMING_TESTPAT_EN
  localparam int PW = 6;
`else
  localparam int PW = 3;
`endif

  logic [11:0]   h_cnt;
  logic [11:0]   v_cnt;
  logic          fv;
  logic          hs_raw;
  logic          vs_raw;
  logic [PW-1:0] stage_in;
  logic [PW-1:0] tap;
  logic [23:0]   colour;
  logic          unused_color;

  logic          hsync_q;
  logic          vsync_q;
  logic          blank_q;
  logic [7:0]    red_q;
  logic [7:0]    green_q;
  logic [7:0]    blue_q;

  // Raster position: h wraps every line, v advances on the last pixel of a line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // 13-bit compares so a 4096-wide total still compares correctly
  assign fv     = ({1'b0, h_cnt} < 13'(H_ACTIVE)) && ({1'b0, v_cnt} < 13'(V_ACTIVE));
  assign hs_raw = ({1'b0, h_cnt} >= 13'(HS_START)) && ({1'b0, h_cnt} < 13'(HS_END));
  assign vs_raw = ({1'b0, v_cnt} >= 13'(VS_START)) && ({1'b0, v_cnt} < 13'(VS_END));

  assign vif.fetch_valid = fv;
  assign vif.next_x      = fv ? COORD_W'(h_cnt) : '0;
  assign vif.next_y      = fv ? COORD_W'(v_cnt) : '0;
  assign vif.line_start  = (h_cnt == 12'd0);
  assign vif.frame_start = (h_cnt == 12'd0) && (v_cnt == 12'd0);

`ifdef VGA_TIMING_TESTPAT_EN
  assign stage_in = {vif.next_x[COORD_W-1 -: 3], fv, hs_raw, vs_raw};
`else
  assign stage_in = {fv, hs_raw, vs_raw};
`endif

  generate
    if (LATENCY > 0) begin : g_dly
      logic [PW-1:0] sr [LATENCY];

      // Delay line matching the frame-buffer read latency; cleared so reset leaks no stale pixels
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < LATENCY; i++) sr[i] <= '0;
        end else begin
          sr[0] <= stage_in;
          for (int i = 1; i < LATENCY; i++) sr[i] <= sr[i-1];
        end
      end

      assign tap = sr[LATENCY-1];
    end else begin : g_nodly
      assign tap = stage_in;
    end
  endgenerate

`ifdef VGA_TIMING_TESTPAT_EN
  // Eight vertical bars chosen by the top three column bits
  always_comb begin
    colour = 24'h000000;
    case (tap[5:3])
      3'd0:    colour = 24'hFFFFFF;
      3'd1:    colour = 24'hFFFF00;
      3'd2:    colour = 24'h00FFFF;
      3'd3:    colour = 24'h00FF00;
      3'd4:    colour = 24'hFF00FF;
      3'd5:    colour = 24'hFF0000;
      3'd6:    colour = 24'h0000FF;
      default: colour = 24'h000000;
    endcase
  end
`else
  assign colour = (GRAY_MODE != 0) ? {3{vif.color_in[7:0]}} : vif.color_in;
`endif

  assign unused_color = ^vif.color_in;

  // DAC output register: sync polarity applied here, colour forced to zero outside the visible area
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync_q <= (H_POL != 0) ? 1'b0 : 1'b1;
      vsync_q <= (V_POL != 0) ? 1'b0 : 1'b1;
      blank_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hsync_q <= (H_POL != 0) ? tap[1] : ~tap[1];
      vsync_q <= (V_POL != 0) ? tap[0] : ~tap[0];
      blank_q <= tap[2];
      red_q   <= tap[2] ? colour[23:16] : 8'h00;
      green_q <= tap[2] ? colour[15:8]  : 8'h00;
      blue_q  <= tap[2] ? colour[7:0]   : 8'h00;
    end
  end

  assign vif.hsync   = hsync_q;
  assign vif.vsync   = vsync_q;
  assign vif.blank_n = blank_q;
  assign vif.sync_n  = 1'b0;
  assign vif.vga_clk = clock;
  assign vif.red     = red_q;
  assign vif.green   = green_q;
  assign vif.blue    = blue_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA driver.
- Generates programmable horizontal/vertical timing with selectable sync polarity, and issues pixel fetch coordinates ahead of display.
- Fetch lead is LATENCY cycles, so a pipelined frame-buffer read can return colour in time.
- Sync and blank are delayed to match the fetch lead; drives the VGA DAC (R/G/B, BLANK_N, SYNC_N, pixel clock) from the 25 MHz system clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front porch (pixels)
- H_PULSE, 96, hsync width (pixels)
- H_BACK, 48, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, front porch (lines)
- V_PULSE, 2, vsync width (lines)
- V_BACK, 33, back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- LATENCY, 2, cycles from fetch coordinate to valid color_in (legal range 0..7)
- GRAY_MODE, 1, 1 = color_in[7:0] replicated on R/G/B; 0 = color_in is {R[23:16],G[15:8],B[7:0]}
- COORD_W, 10, width of coordinate outputs

Ports:
- clock  in  1  pixel clock, 25 MHz
- reset  in  1  asynchronous, active-low reset
- color_in  in  24  pixel colour for the coordinate issued LATENCY cycles earlier
- fetch_valid  out  1  next_x/next_y address a visible pixel this cycle
- next_x  out  COORD_W  fetch column, 0..H_ACTIVE-1; 0 when fetch_valid=0
- next_y  out  COORD_W  fetch line, 0..V_ACTIVE-1; 0 when fetch_valid=0
- line_start  out  1  one-cycle pulse at h=0 (fetch side)
- frame_start  out  1  one-cycle pulse at h=0, v=0 (fetch side)
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- blank_n  out  1  DAC BLANK_N, high = visible pixel, registered
- sync_n  out  1  tied 0
- vga_clk  out  1  equals clock
- red, green, blue  out  8 each  pixel colour, registered, 0 while blank_n=0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_PULSE+H_BACK; V_TOTAL likewise. Counters are 12 bit; H_TOTAL and V_TOTAL must each be at most 4096.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt = H_TOTAL-1 and wraps to 0 after V_TOTAL-1.
- Fetch side, combinational from counters:
  - fetch_valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE), strict less-than.
  - line_start = (h_cnt = 0).
  - frame_start = (h_cnt = 0 && v_cnt = 0).
- Raw sync:
  - hs_raw asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_PULSE.
  - vs_raw asserted for V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_PULSE.
  - vs_raw is evaluated per cycle, so vsync edges align with h_cnt = 0.
- Alignment pipeline: fetch_valid, hs_raw and vs_raw pass through a LATENCY-deep shift register, then one output register.
- At the output register:
  - hsync = H_POL ? hs_d : ~hs_d; vsync likewise with V_POL.
  - blank_n = fv_d.
  - RGB = fv_d ? colour : 0.
- Timing: a pixel fetched at cycle t has color_in sampled at t+LATENCY. It appears on red/green/blue together with its blank_n/hsync/vsync at t+LATENCY+1. LATENCY=0 gives a single register stage.
- GRAY_MODE=1: red=green=blue=color_in[7:0], and color_in[23:8] is ignored.
- Reset (asynchronous assert, synchronous release):
  - h_cnt, v_cnt and all pipeline stages cleared.
  - hsync = ~H_POL and vsync = ~V_POL (inactive levels).
  - blank_n=0, RGB=0.
  - The first cycle after release has h=0, v=0, so frame_start=1 and line_start=1.
- Pipeline contents during reset are discarded, so no stale colour leaks out. A mid-frame reset restarts the frame at (0,0).
- No stall or handshake: color_in must be valid exactly LATENCY cycles after fetch; the block does not check this.

Optional Feature:
- Macro: VGA_TIMING_TESTPAT_EN.
- Defined: an internal 8-bar colour pattern replaces color_in.
  - Bar index = next_x[COORD_W-1 : COORD_W-3] at fetch time, delayed through the same pipeline.
  - Bars in order: white, yellow, cyan, green, magenta, red, blue, black (8'hFF/8'h00 per channel).
  - GRAY_MODE is ignored in this mode.
- Undefined: no pattern logic; color_in is always used.

Test Plan:
- Defaults, LATENCY=2, free run 2 frames -> H_TOTAL=800 cycles per line; V_TOTAL=525 lines per frame; frame_start every 420000 cycles; exactly 307200 cycles with blank_n=1 per frame.
- Sync placement (defaults) -> hsync low for 96 cycles, starting 656+3 cycles after line_start; vsync low for exactly 2*800 cycles, starting with the line whose v_cnt=490.
- Latency alignment: color_in = low 8 bits of (next_x) delayed 2 cycles, GRAY_MODE=1 -> first visible pixel of each line shows red=green=blue=0x00; pixel 255 shows 0xFF; all channels 0 whenever blank_n=0.
- GRAY_MODE=0, H_POL=1, V_POL=1, color_in=24'h12_34_56 constant -> RGB = 0x12/0x34/0x56 in the active region; hsync/vsync idle low, pulse high.
- Reset asserted mid-line (h=300, v=100) for 5 cycles -> RGB=0, blank_n=0, syncs inactive immediately; after release, frame_start=1 on the first cycle and next_x/next_y = 0,0.
- Small timing (H 8/2/2/2, V 4/1/1/1, LATENCY=0) -> blank_n pattern 8 on, 6 off, per line; 4 visible lines per 7-line frame.
